// File: rtl/breath_led_core.sv
// breath_led_core: PWM breathing engine. It reads the four slave config words and
// drives the LED with a ramp-up / hold / ramp-down / hold duty profile.
// Config is sampled into shadow registers only at PWM period boundaries.
// Optional macro BREATH_LED_GAMMA_EN: the PWM compare uses a registered
// (duty*duty)>>PWM_W value, while the duty port still reports linear duty.
module breath_led_core #(
    parameter int unsigned PWM_W  = 8,
    parameter int unsigned PRE_W  = 32,
    parameter int unsigned STEP_W = 8,
    parameter int unsigned HOLD_W = 16,
    parameter int unsigned CYC_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       cfg_ctrl,
    input  logic [PRE_W-1:0]  cfg_prescale,
    input  logic [STEP_W-1:0] cfg_step,
    input  logic [HOLD_W-1:0] cfg_hold,
    output logic              led,
    output logic [2:0]        state,
    output logic [PWM_W-1:0]  duty,
    output logic [CYC_W-1:0]  cycle_cnt
);

    localparam int unsigned SUM_W = ((PWM_W > STEP_W) ? PWM_W : STEP_W) + 1;
    localparam logic [PWM_W-1:0] DUTY_MAX = '1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HIGH = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LOW  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;
    logic [PWM_W-1:0]    duty_q, duty_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CYC_W-1:0]    cycle_q, cycle_d;
    logic [PRE_W-1:0]    pre_sh_q, pre_sh_d;
    logic [STEP_W-1:0]   step_sh_q, step_sh_d;
    logic [HOLD_W-1:0]   hold_sh_q, hold_sh_d;
    logic                invert_sh_q, invert_sh_d;
    logic                led_q, led_d;

    logic                enable;
    logic                invert_in;
    logic                tick;
    logic                pb;
    logic                load_sh;
    logic [SUM_W-1:0]    up_sum;
    logic [PWM_W-1:0]    duty_up;
    logic [PWM_W-1:0]    duty_dn;
    logic [PWM_W-1:0]    duty_cmp;
    logic                unused_ctrl;

    assign enable      = cfg_ctrl[0];
    assign invert_in   = cfg_ctrl[1];
    assign unused_ctrl = ^cfg_ctrl[31:2];

    assign tick = (state_q != IDLE) && (pre_cnt_q == pre_sh_q);
    assign pb   = tick && (pwm_cnt_q == DUTY_MAX);

    // Saturating duty step in both directions; the extra sum bit stops wrap.
    assign up_sum  = SUM_W'(duty_q) + SUM_W'(step_sh_q);
    assign duty_up = (up_sum >= SUM_W'(DUTY_MAX)) ? DUTY_MAX : PWM_W'(up_sum);
    assign duty_dn = (SUM_W'(step_sh_q) >= SUM_W'(duty_q)) ? '0
                   : PWM_W'(SUM_W'(duty_q) - SUM_W'(step_sh_q));

`ifdef BREATH_LED_GAMMA_EN
    localparam int unsigned PROD_W = 2 * PWM_W;
    logic [PWM_W-1:0] duty_g_q;

    // Squared duty for a perceptually smoother ramp, one clock behind duty.
    always_ff @(posedge clock) begin
        if (reset) begin
            duty_g_q <= '0;
        end else begin
            duty_g_q <= PWM_W'((PROD_W'(duty_q) * PROD_W'(duty_q)) >> PWM_W);
        end
    end

    assign duty_cmp = duty_g_q;
`else
    assign duty_cmp = duty_q;
`endif

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            pre_cnt_q   <= '0;
            pwm_cnt_q   <= '0;
            duty_q      <= '0;
            hold_cnt_q  <= '0;
            cycle_q     <= '0;
            pre_sh_q    <= '0;
            step_sh_q   <= '0;
            hold_sh_q   <= '0;
            invert_sh_q <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            duty_q      <= duty_d;
            hold_cnt_q  <= hold_cnt_d;
            cycle_q     <= cycle_d;
            pre_sh_q    <= pre_sh_d;
            step_sh_q   <= step_sh_d;
            hold_sh_q   <= hold_sh_d;
            invert_sh_q <= invert_sh_d;
            led_q       <= led_d;
        end
    end

    // Next-state, counters, duty profile and LED compare.
    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        pwm_cnt_d   = pwm_cnt_q;
        duty_d      = duty_q;
        hold_cnt_d  = hold_cnt_q;
        cycle_d     = cycle_q;
        pre_sh_d    = pre_sh_q;
        step_sh_d   = step_sh_q;
        hold_sh_d   = hold_sh_q;
        invert_sh_d = invert_sh_q;
        led_d       = invert_in;
        load_sh     = 1'b0;

        if (state_q == IDLE || !enable) begin
            // Idle or enable dropped: counters and duty cleared, cycle count kept.
            state_d    = IDLE;
            pre_cnt_d  = '0;
            pwm_cnt_d  = '0;
            duty_d     = '0;
            hold_cnt_d = '0;
            if (state_q == IDLE && enable) begin
                state_d = RAMP_UP;
                load_sh = 1'b1;
            end
        end else begin
            led_d = (pwm_cnt_q < duty_cmp) ^ invert_sh_q;
            if (tick) begin
                pre_cnt_d = '0;
                pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
            end else begin
                pre_cnt_d = pre_cnt_q + PRE_W'(1);
            end

            if (pb) begin
                load_sh = 1'b1;
                case (state_q)
                    RAMP_UP: begin
                        duty_d = duty_up;
                        if (duty_up == DUTY_MAX) begin
                            state_d    = HOLD_HIGH;
                            hold_cnt_d = '0;
                        end
                    end
                    HOLD_HIGH: begin
                        if (hold_cnt_q >= hold_sh_q) begin
                            state_d = RAMP_DOWN;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                        end
                    end
                    RAMP_DOWN: begin
                        duty_d = duty_dn;
                        if (duty_dn == '0) begin
                            state_d    = HOLD_LOW;
                            hold_cnt_d = '0;
                        end
                    end
                    HOLD_LOW: begin
                        if (hold_cnt_q >= hold_sh_q) begin
                            state_d = RAMP_UP;
                            cycle_d = cycle_q + CYC_W'(1);
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end

        if (load_sh) begin
            pre_sh_d    = cfg_prescale;
            step_sh_d   = cfg_step;
            hold_sh_d   = cfg_hold;
            invert_sh_d = invert_in;
        end
    end

    assign led       = led_q;
    assign state     = state_q;
    assign duty      = duty_q;
    assign cycle_cnt = cycle_q;

endmodule

// File: tb/tb_breath_led_core.sv
// tb_breath_led_core: directed bench for breath_led_core with hand-computed
// duty sequences, period lengths and LED on-times.
module tb_breath_led_core;

    logic        clock;
    logic        reset;
    logic [31:0] cfg_ctrl;
    logic [31:0] cfg_prescale;
    logic [7:0]  cfg_step;
    logic [15:0] cfg_hold;
    logic        led;
    logic [2:0]  state;
    logic [7:0]  duty;
    logic [15:0] cycle_cnt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;

    int unsigned exp_duty [8] = '{64, 128, 192, 255, 191, 127, 63, 0};
    int unsigned exp_st   [8] = '{1, 1, 1, 2, 3, 3, 3, 4};
    int unsigned exp_gap  [8] = '{0, 256, 256, 256, 512, 256, 256, 256};

    breath_led_core dut (
        .clock        (clock),
        .reset        (reset),
        .cfg_ctrl     (cfg_ctrl),
        .cfg_prescale (cfg_prescale),
        .cfg_step     (cfg_step),
        .cfg_hold     (cfg_hold),
        .led          (led),
        .state        (state),
        .duty         (duty),
        .cycle_cnt    (cycle_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Free-running clock counter used to time events.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b1;
        cfg_ctrl = 32'h0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_duty_change(input int budget, output logic ok);
        logic [7:0] prev;
        prev = duty;
        ok   = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clock);
            if (duty !== prev) ok = 1'b1;
        end
    endtask

    task automatic wait_led_rise(input int budget, output logic ok);
        logic prev;
        prev = led;
        ok   = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clock);
            if (prev === 1'b0 && led === 1'b1) ok = 1'b1;
            prev = led;
        end
    endtask

    task automatic count_high(input int n, output int unsigned hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (led === 1'b1) hi++;
        end
    endtask

    initial begin
        logic        ok;
        int unsigned t0, t1, t2, hi;

        reset        = 1'b0;
        cfg_ctrl     = 32'h0;
        cfg_prescale = 32'd0;
        cfg_step     = 8'd64;
        cfg_hold     = 16'd0;

        // Reset held with enable high.
        @(negedge clock);
        reset    = 1'b1;
        cfg_ctrl = 32'h1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_led", 32'(led), 32'd0);
            check("rst_state", 32'(state), 32'd0);
            check("rst_duty", 32'(duty), 32'd0);
            check("rst_cycle", 32'(cycle_cnt), 32'd0);
        end

        // Full breath cycle: prescale 0, step 64, hold 0.
        reset = 1'b0;
        t0 = 0;
        for (int i = 0; i < 8; i++) begin
            wait_duty_change(600, ok);
            check("cyc_evt_ok", 32'(ok), 32'd1);
            check("cyc_duty", 32'(duty), exp_duty[i]);
            check("cyc_state", 32'(state), exp_st[i]);
            if (i > 0) check("cyc_gap", cyc - t0, exp_gap[i]);
            t0 = cyc;
        end
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clock);
            if (state === 3'd1) ok = 1'b1;
        end
        check("reentry_ok", 32'(ok), 32'd1);
        check("reentry_gap", cyc - t0, 32'd256);
        check("reentry_cycle", 32'(cycle_cnt), 32'd1);
        check("reentry_duty", 32'(duty), 32'd0);

        // Drop enable in RAMP_DOWN at duty 127 with invert set.
        cfg_ctrl = 32'h3;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clock);
            if (duty === 8'd127 && state === 3'd3) ok = 1'b1;
        end
        check("drop_reach_ok", 32'(ok), 32'd1);
        cfg_ctrl = 32'h2;
        @(negedge clock);
        check("drop_state", 32'(state), 32'd0);
        check("drop_duty", 32'(duty), 32'd0);
        check("drop_led", 32'(led), 32'd1);
        check("drop_cycle", 32'(cycle_cnt), 32'd1);

        // Prescale 3, duty frozen at 64: 1024-clock period, 256 on.
        do_reset();
        cfg_prescale = 32'd3;
        cfg_step     = 8'd64;
        cfg_hold     = 16'd0;
        cfg_ctrl     = 32'h1;
        @(negedge clock);
        check("pre3_state", 32'(state), 32'd1);
        cfg_step = 8'd0;
        wait_duty_change(1100, ok);
        check("pre3_evt_ok", 32'(ok), 32'd1);
        check("pre3_duty", 32'(duty), 32'd64);
        wait_led_rise(1100, ok);
        check("pre3_rise1_ok", 32'(ok), 32'd1);
        t0 = cyc;
        wait_led_rise(1100, ok);
        check("pre3_rise2_ok", 32'(ok), 32'd1);
        check("pre3_period", cyc - t0, 32'd1024);
        count_high(1024, hi);
        check("pre3_on", hi, 32'd256);
        cfg_ctrl = 32'h3;
        repeat (1100) @(negedge clock);
        count_high(1024, hi);
        check("pre3_inv_on", hi, 32'd768);
        check("pre3_duty_hold", 32'(duty), 32'd64);

        // Prescale change mid-period only affects the period after next boundary.
        do_reset();
        cfg_prescale = 32'd0;
        cfg_step     = 8'd1;
        cfg_ctrl     = 32'h1;
        wait_duty_change(400, ok);
        check("ps_evt1_ok", 32'(ok), 32'd1);
        check("ps_duty1", 32'(duty), 32'd1);
        t0 = cyc;
        repeat (100) @(negedge clock);
        cfg_prescale = 32'd9;
        wait_duty_change(400, ok);
        check("ps_evt2_ok", 32'(ok), 32'd1);
        t1 = cyc;
        check("ps_gap_old", t1 - t0, 32'd256);
        wait_duty_change(3000, ok);
        check("ps_evt3_ok", 32'(ok), 32'd1);
        t2 = cyc;
        check("ps_gap_new", t2 - t1, 32'd2560);
        check("ps_duty3", 32'(duty), 32'd3);

        // Duty frozen at 128: on-time depends on the gamma option.
        do_reset();
        cfg_prescale = 32'd0;
        cfg_step     = 8'd128;
        cfg_ctrl     = 32'h1;
        @(negedge clock);
        cfg_step = 8'd0;
        wait_duty_change(400, ok);
        check("g_evt_ok", 32'(ok), 32'd1);
        check("g_duty", 32'(duty), 32'd128);
        repeat (5) @(negedge clock);
        count_high(256, hi);
`ifdef BREATH_LED_GAMMA_EN
        check("g_on", hi, 32'd64);
`else
        check("g_on", hi, 32'd128);
`endif

        // Reset mid-operation with enable still high.
        reset = 1'b1;
        @(negedge clock);
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_duty", 32'(duty), 32'd0);
        check("midrst_led", 32'(led), 32'd0);
        check("midrst_cycle", 32'(cycle_cnt), 32'd0);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/breath_led_core.md
Name: breath_led_core

Overview:
- PWM breathing engine sitting directly downstream of the breath_led_ip AXI4-Lite register slave.
- Consumes the four slave registers as config words and drives the physical LED pin with a triangular (ramp up / hold / ramp down / hold) duty profile.
- All config changes are applied only at PWM period boundaries, so no glitches occur mid-period.

Parameters:
- PWM_W, 8, PWM counter/duty width; DUTY_MAX = 2^PWM_W-1.
- PRE_W, 32, prescaler width.
- STEP_W, 8, duty increment width.
- HOLD_W, 16, hold-period counter width.
- CYC_W, 16, breath-cycle counter width.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- cfg_ctrl  in  32  slv_reg0: bit0 enable, bit1 invert; other bits ignored.
- cfg_prescale  in  PRE_W  slv_reg1: clocks per PWM slot = value+1.
- cfg_step  in  STEP_W  slv_reg2[STEP_W-1:0]: duty change per PWM period.
- cfg_hold  in  HOLD_W  slv_reg3[HOLD_W-1:0]: PWM periods held at top and bottom.
- led  out  1  LED drive, registered.
- state  out  3  FSM state: IDLE=0, RAMP_UP=1, HOLD_HIGH=2, RAMP_DOWN=3, HOLD_LOW=4.
- duty  out  PWM_W  current duty.
- cycle_cnt  out  CYC_W  completed breath cycles.

Behaviour:
- Reset values: led=0, state=IDLE, duty=0, cycle_cnt=0. All internal counters are 0.
- Prescaler: pre_cnt counts 0..pre_sh. It asserts a 1-clock tick when pre_cnt==pre_sh, then wraps to 0.
- PWM counter: pwm_cnt increments on tick and wraps DUTY_MAX->0.
- Period boundary (pb) = tick && pwm_cnt==DUTY_MAX.
- led = (pwm_cnt < duty) ^ invert_sh, registered, so led lags pwm_cnt by 1 clock.
  - duty=0 gives fully off.
  - duty=DUTY_MAX gives on for DUTY_MAX of 2^PWM_W slots.
- Shadow regs pre_sh, step_sh, hold_sh and invert_sh load on the IDLE->RAMP_UP transition and on every pb. They never load mid-period.
- IDLE:
  - pre_cnt, pwm_cnt and duty are held at 0; led = cfg_ctrl[1] registered.
  - On enable=1, go to RAMP_UP next clock and load shadows.
- RAMP_UP:
  - On pb, duty = min(duty+step_sh, DUTY_MAX), with an internal carry bit so there is no wrap.
  - If the result is DUTY_MAX, go to HOLD_HIGH with hold_cnt=0.
- HOLD_HIGH:
  - On pb, if hold_cnt >= hold_sh go to RAMP_DOWN; else hold_cnt++.
  - hold_sh=0 therefore holds for exactly 1 period.
- RAMP_DOWN:
  - On pb, duty = max(duty-step_sh, 0), saturating.
  - If the result is 0, go to HOLD_LOW with hold_cnt=0.
- HOLD_LOW:
  - Same hold rule as HOLD_HIGH.
  - On exit, go to RAMP_UP and increment cycle_cnt, which wraps 2^CYC_W-1 -> 0.
- step_sh=0: duty freezes and the FSM stays in its ramp state indefinitely. This is legal; no error.
- Enable deasserted in any non-IDLE state:
  - Next clock, state=IDLE, duty=0 and counters clear.
  - cycle_cnt is retained.
  - This has priority over a simultaneous pb.
- cfg_prescale changed mid-period: takes effect after the next pb. The current period completes with the old value.
- reset mid-operation: all state returns to reset values on the next edge, regardless of enable.

Optional Feature:
- Macro BREATH_LED_GAMMA_EN.
- When defined: the PWM compare uses duty_g = (duty*duty)>>PWM_W, registered, adding 1 clock of compare latency. The duty port still reports the linear duty.
- When undefined: the compare uses linear duty directly, with no extra multiplier or register.

Test Plan:
- reset=1 for 3 clocks with enable=1 -> led=0, state=0, duty=0, cycle_cnt=0 throughout.
- prescale=0, step=64, hold=0, enable=1 -> duty after successive pb: 64, 128, 192, 255 (state 2), hold 1 period, then 191, 127, 63, 0 (state 4), hold 1 period. At re-entry to state 1, cycle_cnt=1.
- prescale=3, duty fixed at 64 (step=64, sampled after first pb) -> each PWM period is 1024 clocks with led high for exactly 256 clocks. invert=1 gives led high for 768 clocks.
- Change prescale 0->9 mid-period -> current period remains 256 clocks; the following period is 2560 clocks.
- Drop enable while in RAMP_DOWN with duty=127 -> next clock state=0, duty=0, led=invert. cycle_cnt is unchanged.
- With BREATH_LED_GAMMA_EN, duty=128 -> led high for 64 of 256 slots. Without it, led is high for 128 slots.
